// File: rtl/io_device_port_if.sv
// Processor-side IO handshake: input request/response and output write strobe.
interface io_device_port_if;
  logic        stop;
  logic        write_io;
  logic [31:0] out_data;
  logic [31:0] in_data;
  logic        flag_in;

  modport master (output stop, output write_io, output out_data,
                  input in_data, input flag_in);
  modport slave  (input stop, input write_io, input out_data,
                  output in_data, output flag_in);
endinterface

// File: rtl/io_device_port.sv
// Board-side responder for the processor IO port: debounced switch/button input
// and output capture. Define IO_DEV_SIGN_EXT_EN to sign-extend latched switches.
//
// state   | meaning
// IDLE    | no pending request, or waiting for a held button to be released
// ARMED   | processor stalled on input, waiting for a confirm press
// PRESENT | in_data valid, flag_in high until the processor drops stop
// RELEASE | value consumed, waiting for the button to go up
module io_device_port #(
  parameter int SW_W            = 16,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CNT_W           = 16
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [SW_W-1:0]    switches,
  input  logic               button,
  io_device_port_if.slave    io,
  output logic [31:0]        display,
  output logic [7:0]         out_count,
  output logic               waiting
);

  typedef enum logic [1:0] {IDLE, ARMED, PRESENT, RELEASE} state_t;

  state_t            state, state_nxt;
  logic              sync1, sync2;
  logic              btn_db, btn_db_q;
  logic [CNT_W-1:0]  db_cnt;
  logic              press;
  logic [31:0]       sw_ext;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= button;
      sync2 <= sync1;
    end
  end

  // Level flips on the DEBOUNCE_CYCLES-th consecutive mismatching sample.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      db_cnt   <= '0;
      btn_db   <= 1'b0;
      btn_db_q <= 1'b0;
    end else begin
      btn_db_q <= btn_db;
      if (sync2 != btn_db) begin
        if (db_cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
          btn_db <= sync2;
          db_cnt <= '0;
        end else begin
          db_cnt <= db_cnt + 1'b1;
        end
      end else begin
        db_cnt <= '0;
      end
    end
  end

  assign press = btn_db & ~btn_db_q;

  always_comb begin
`ifdef IO_DEV_SIGN_EXT_EN
    sw_ext = {32{switches[SW_W-1]}};
`else
    sw_ext = '0;
`endif
    sw_ext[SW_W-1:0] = switches;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    io.flag_in = 1'b0;
    waiting    = 1'b0;
    case (state)
      IDLE: begin
        if (io.stop && !btn_db) state_nxt = ARMED;
      end
      ARMED: begin
        waiting = 1'b1;
        if (press)         state_nxt = PRESENT;
        else if (!io.stop) state_nxt = IDLE;
      end
      PRESENT: begin
        io.flag_in = 1'b1;
        if (!io.stop) state_nxt = RELEASE;
      end
      RELEASE: begin
        if (!btn_db) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      io.in_data <= '0;
    end else if (state == ARMED && press) begin
      io.in_data <= sw_ext;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      display   <= '0;
      out_count <= '0;
    end else if (io.write_io) begin
      display   <= io.out_data;
      out_count <= out_count + 8'd1;
    end
  end

endmodule

// File: tb/tb_io_device_port.sv
// Directed bench for io_device_port with a scoreboard of expected input values.
module tb_io_device_port;
  localparam int SW_W = 16;
  localparam int DEB  = 4;
  localparam int LAT  = 2 + DEB + 1;

  logic            clock = 1'b0;
  logic            reset;
  logic [SW_W-1:0] switches;
  logic            button;
  logic [31:0]     display;
  logic [7:0]      out_count;
  logic            waiting;

  io_device_port_if io();

  io_device_port #(.SW_W(SW_W), .DEBOUNCE_CYCLES(DEB), .CNT_W(4)) dut (
    .clock(clock), .reset(reset), .switches(switches), .button(button),
    .io(io), .display(display), .out_count(out_count), .waiting(waiting)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  int pres_cnt = 0;
  logic flag_d = 1'b0;
  logic [31:0] exp_q[$];

  always @(negedge clock) begin
    if (io.flag_in && !flag_d) pres_cnt++;
    flag_d = io.flag_in;
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Press and hold; wait (bounded) for flag_in, then score in_data.
  task automatic press_until_flag(input string tag);
    int lat;
    logic [31:0] exp;
    button = 1'b1;
    lat = 0;
    while (!io.flag_in && lat < 40) begin
      tick();
      lat++;
    end
    check({tag, "_latency"}, lat, LAT);
    check({tag, "_waiting_fell"}, waiting, 1'b0);
    if (exp_q.size() > 0) begin
      exp = exp_q.pop_front();
      check({tag, "_in_data"}, io.in_data, exp);
    end else begin
      check({tag, "_scoreboard_empty"}, 32'd0, 32'd1);
    end
  endtask

  task automatic consume(input string tag);
    tick();
    check({tag, "_flag_cycle2"}, io.flag_in, 1'b1);
    io.stop = 1'b0;
    tick();
    check({tag, "_flag_fell"}, io.flag_in, 1'b0);
  endtask

  initial begin
    int base;
    reset = 1'b0;
    switches = '0;
    button = 1'b0;
    io.stop = 1'b0;
    io.write_io = 1'b0;
    io.out_data = '0;
    ticks(3);
    check("rst_in_data", io.in_data, 32'h0);
    check("rst_flag", io.flag_in, 1'b0);
    check("rst_display", display, 32'h0);
    check("rst_count", out_count, 8'h0);
    check("rst_waiting", waiting, 1'b0);
    reset = 1'b1;
    ticks(2);

    // clean press, zero-extended value
    io.stop = 1'b1;
    switches = 16'h00A5;
    ticks(2);
    check("a_waiting", waiting, 1'b1);
    exp_q.push_back(32'h0000_00A5);
    press_until_flag("a");
    consume("a");
    button = 1'b0;
    ticks(10);
    check("a_idle_waiting", waiting, 1'b0);

    // output path with wrap
    for (int k = 0; k < 256; k++) begin
      io.out_data = k;
      io.write_io = 1'b1;
      tick();
      io.write_io = 1'b0;
      if (k == 254) check("wr_count_255", out_count, 8'd255);
    end
    check("wr_count_wrap", out_count, 8'd0);
    check("wr_display_255", display, 32'd255);

    // MSB-set switches, plus one write landing in PRESENT
    io.stop = 1'b1;
    switches = 16'h8001;
    ticks(2);
`ifdef IO_DEV_SIGN_EXT_EN
    exp_q.push_back(32'hFFFF_8001);
`else
    exp_q.push_back(32'h0000_8001);
`endif
    press_until_flag("b");
    io.out_data = 32'd256;
    io.write_io = 1'b1;
    tick();
    io.write_io = 1'b0;
    check("b_flag_cycle2", io.flag_in, 1'b1);
    check("b_display_256", display, 32'd256);
    check("b_count_1", out_count, 8'd1);
    io.stop = 1'b0;
    tick();
    check("b_flag_fell", io.flag_in, 1'b0);
    button = 1'b0;
    ticks(10);

    // bouncing button while ARMED
    io.stop = 1'b1;
    switches = 16'h1234;
    ticks(2);
    base = pres_cnt;
    for (int g = 0; g < 3; g++) begin
      button = 1'b1;
      ticks(3);
      button = 1'b0;
      ticks(3);
    end
    ticks(4);
    check("c_bounce_no_pres", pres_cnt, base);
    check("c_bounce_waiting", waiting, 1'b1);
    exp_q.push_back(32'h0000_1234);
    press_until_flag("c");
    consume("c");
    check("c_one_pres", pres_cnt, base + 1);
    // second request with the button still held
    ticks(2);
    io.stop = 1'b1;
    ticks(15);
    check("c_held_no_pres", pres_cnt, base + 1);
    check("c_held_waiting", waiting, 1'b0);
    check("c_held_flag", io.flag_in, 1'b0);
    button = 1'b0;
    ticks(10);
    check("c_rearmed", waiting, 1'b1);
    switches = 16'h0F0F;
    exp_q.push_back(32'h0000_0F0F);
    press_until_flag("c2");
    consume("c2");
    check("c_two_pres", pres_cnt, base + 2);
    button = 1'b0;
    ticks(10);

    // stop pulse with no press
    base = pres_cnt;
    switches = 16'h7777;
    io.stop = 1'b1;
    ticks(3);
    check("d_waiting", waiting, 1'b1);
    io.stop = 1'b0;
    ticks(2);
    check("d_back_idle", waiting, 1'b0);
    check("d_no_flag", pres_cnt, base);
    check("d_in_data_kept", io.in_data, 32'h0000_0F0F);

    // async reset while presenting
    io.stop = 1'b1;
    switches = 16'h5555;
    ticks(2);
    exp_q.push_back(32'h0000_5555);
    press_until_flag("e");
    reset = 1'b0;
    #2;
    check("e_flag_async", io.flag_in, 1'b0);
    check("e_in_data_async", io.in_data, 32'h0);
    check("e_display_async", display, 32'h0);
    check("e_count_async", out_count, 8'h0);
    check("e_waiting_async", waiting, 1'b0);
    button = 1'b0;
    io.stop = 1'b0;
    #1;
    reset = 1'b1;
    ticks(3);
    check("e_post_waiting", waiting, 1'b0);
    check("e_post_flag", io.flag_in, 1'b0);
    io.stop = 1'b1;
    tick();
    check("e_idle_to_armed", waiting, 1'b1);
    io.stop = 1'b0;
    ticks(2);
    check("e_scoreboard_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
